// File: rtl/weight_read_sequencer_if.sv
// Bundles the command, weight-memory and MAC stream signals of the weight read sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface weight_read_sequencer_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    start;
    logic [addressWidth:0]   base_addr;
    logic [addressWidth:0]   len;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    mem_ren;
    logic [addressWidth:0]   mem_raddr;
    logic [dataWidth-1:0]    mem_wout;
    logic [dataWidth-1:0]    w_data;
    logic                    w_valid;
    logic                    w_last;
    logic                    w_ready;

    modport master (
        input  start, base_addr, len, abort, mem_wout, w_ready,
        output busy, done, mem_ren, mem_raddr, w_data, w_valid, w_last
    );

    modport slave (
        output start, base_addr, len, abort, mem_wout, w_ready,
        input  busy, done, mem_ren, mem_raddr, w_data, w_valid, w_last
    );
endinterface

// File: rtl/weight_read_sequencer.sv
// Streams one neuron's weights from a 1-cycle-latency memory to the MAC over valid/ready,
// using a 2-entry skid buffer (plus the in-flight read) so backpressure never drops or repeats a word.
module weight_read_sequencer #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    weight_read_sequencer_if.master bus
);
    localparam int AW = addressWidth + 1;
    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [AW-1:0] ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [AW-1:0]        r_base;
    logic [AW-1:0]        r_len;
    logic [AW-1:0]        r_issued;
    logic [AW-1:0]        r_popped;
    logic [AW-1:0]        r_raddr;
    logic                 r_inflight;
    logic [dataWidth-1:0] r_fifo [2];
    logic [1:0]           r_cnt;
    logic                 r_rd;
    logic                 r_wr;

    logic                 w_run;
    logic                 w_head_fifo;
    logic                 w_valid;
    logic                 w_pop;
    logic                 w_fifo_pop;
    logic                 w_push;
    logic [2:0]           w_occ;
    logic                 w_ren;
    logic [AW-1:0]        w_addr_next;
    logic                 w_is_last;

    assign w_run       = (r_state == S_RUN);
    assign w_head_fifo = (r_cnt != 2'd0);
    // With the buffer empty, the word returning from memory is presented directly to the MAC.
    assign w_valid     = w_head_fifo | r_inflight;
    assign w_pop       = w_valid & bus.w_ready;
    assign w_fifo_pop  = w_pop & w_head_fifo;
    assign w_push      = r_inflight & ~(w_pop & ~w_head_fifo);
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_ren       = w_run & ~bus.abort & (r_issued < r_len) & (w_occ < 3'd2);
    assign w_addr_next = r_base + r_issued;
    assign w_is_last   = (r_popped == (r_len - ONE));

    assign bus.w_valid   = w_valid;
    assign bus.w_data    = w_head_fifo ? r_fifo[r_rd] : (r_inflight ? bus.mem_wout : '0);
    assign bus.w_last    = w_valid & w_is_last;
    assign bus.mem_ren   = w_ren;
    assign bus.mem_raddr = w_ren ? w_addr_next : r_raddr;
    assign bus.busy      = w_run;
    assign bus.done      = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_raddr    <= '0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_cnt      <= 2'd0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_base     <= bus.base_addr;
                        r_len      <= bus.len;
                        r_issued   <= '0;
                        r_popped   <= '0;
                        r_inflight <= 1'b0;
                        r_cnt      <= 2'd0;
                        r_rd       <= 1'b0;
                        r_wr       <= 1'b0;
                        r_state    <= (bus.len != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state    <= S_IDLE;
                        r_inflight <= 1'b0;
                        r_cnt      <= 2'd0;
                        r_rd       <= 1'b0;
                        r_wr       <= 1'b0;
                    end else begin
                        r_inflight <= w_ren;
                        if (w_ren) begin
                            r_issued <= r_issued + ONE;
                            r_raddr  <= w_addr_next;
                        end
                        if (w_push) begin
                            r_fifo[r_wr] <= bus.mem_wout;
                            r_wr         <= ~r_wr;
                        end
                        if (w_fifo_pop)
                            r_rd <= ~r_rd;
                        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};
                        if (w_pop) begin
                            r_popped <= r_popped + ONE;
                            if (w_is_last)
                                r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer: memory model returns 0x100+addr one cycle after mem_ren.
module tb_weight_read_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    weight_read_sequencer_if #(.addressWidth(10), .dataWidth(16)) bus ();
    weight_read_sequencer #(.addressWidth(10), .dataWidth(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_ren) bus.mem_wout <= 16'h0100 + {5'b00000, bus.mem_raddr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_ren"},   32'(bus.mem_ren), 0);
        check({tag, "_raddr"}, 32'(bus.mem_raddr), 0);
        check({tag, "_valid"}, 32'(bus.w_valid), 0);
        check({tag, "_last"},  32'(bus.w_last), 0);
        check({tag, "_data"},  32'(bus.w_data), 0);
    endtask

    // Runs one burst with w_ready taken from pat (bit per cycle) and scoreboards every cycle.
    task automatic run_burst(input string tag, input logic [10:0] b, input logic [10:0] l,
                             input logic [31:0] pat, input bit restart);
        int          hs, nren, cyc, occ;
        bit          stalled, got_done;
        logic [15:0] held;
        logic [10:0] a;
        hs = 0; nren = 0; cyc = 0; stalled = 0; got_done = 0; held = '0;
        bus.base_addr = b; bus.len = l; bus.start = 1'b1; bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!got_done && cyc < 300) begin
            bus.w_ready = pat[cyc % 32];
            if (restart) begin
                bus.start = 1'b1; bus.base_addr = 11'd500; bus.len = 11'd9;
            end
            #1;
            if (bus.done) begin
                got_done  = 1;
                bus.start = 1'b0;
                check({tag, "_done_valid"}, 32'(bus.w_valid), 0);
                check({tag, "_done_busy"},  32'(bus.busy), 0);
                check({tag, "_done_ren"},   32'(bus.mem_ren), 0);
            end else begin
                check({tag, "_busy"}, 32'(bus.busy), 1);
                occ = nren - hs;
                check({tag, "_occ_le2"}, 32'(occ <= 2), 1);
                if (stalled) begin
                    check({tag, "_stall_valid"}, 32'(bus.w_valid), 1);
                    check({tag, "_stall_data"},  32'(bus.w_data), 32'(held));
                end
                if (occ == 2 && !(bus.w_valid && bus.w_ready))
                    check({tag, "_full_ren"}, 32'(bus.mem_ren), 0);
                if (bus.mem_ren) begin
                    a = b + nren[10:0];
                    check({tag, "_raddr"}, 32'(bus.mem_raddr), 32'(a));
                    nren++;
                end
                if (bus.w_valid) begin
                    a = b + hs[10:0];
                    check({tag, "_data"}, 32'(bus.w_data), 32'h100 + 32'(a));
                    check({tag, "_last"}, 32'(bus.w_last), 32'(hs == int'(l) - 1));
                end
                stalled = bus.w_valid && !bus.w_ready;
                held    = bus.w_data;
                if (bus.w_valid && bus.w_ready) hs++;
            end
            tick();
            cyc++;
        end
        check({tag, "_got_done"}, 32'(got_done), 1);
        check({tag, "_handshakes"}, 32'(hs), 32'(l));
        check({tag, "_reads"}, 32'(nren), 32'(l));
        check({tag, "_done_pulse_end"}, 32'(bus.done), 0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int hs, cyc;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.abort = 1'b0; bus.w_ready = 1'b0;
        #2;
        check_idle_outputs("reset");
        #10 rst_n = 1'b1;
        tick();

        // Basic burst with exact cycle timing: base 0, len 4, always ready.
        bus.base_addr = 11'd0; bus.len = 11'd4; bus.start = 1'b1; bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("basic_ren_c%0d", c),   32'(bus.mem_ren), 32'(c <= 4));
            check($sformatf("basic_raddr_c%0d", c), 32'(bus.mem_raddr), (c <= 4) ? 32'(c - 1) : 32'd3);
            check($sformatf("basic_valid_c%0d", c), 32'(bus.w_valid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5)
                check($sformatf("basic_data_c%0d", c), 32'(bus.w_data), 32'h100 + 32'(c - 2));
            check($sformatf("basic_last_c%0d", c),  32'(bus.w_last), 32'(c == 5));
            check($sformatf("basic_done_c%0d", c),  32'(bus.done), 32'(c == 6));
            check($sformatf("basic_busy_c%0d", c),  32'(bus.busy), 32'(c <= 5));
            tick();
        end

        run_burst("bp",   11'd0,    11'd8, 32'hC6A3_5D29, 1'b0);
        run_burst("zero", 11'd5,    11'd0, 32'hFFFF_FFFF, 1'b0);
        run_burst("wrap", 11'd2046, 11'd4, 32'hFFFF_FFFF, 1'b0);

        // Abort after the 5th handshake, once the stalled buffer is full.
        bus.base_addr = 11'd0; bus.len = 11'd16; bus.start = 1'b1; bus.w_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 50) begin
            if (bus.w_valid) hs++;
            tick();
            cyc++;
        end
        check("abort_reach_5", 32'(hs), 5);
        bus.w_ready = 1'b0;
        #1;
        cyc = 0;
        while (bus.mem_ren && cyc < 10) begin
            tick();
            #1;
            cyc++;
        end
        check("abort_full_ren", 32'(bus.mem_ren), 0);
        check("abort_full_valid", 32'(bus.w_valid), 1);
        check("abort_full_data", 32'(bus.w_data), 32'h105);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_valid", 32'(bus.w_valid), 0);
        check("abort_ren",   32'(bus.mem_ren), 0);
        check("abort_busy",  32'(bus.busy), 0);
        check("abort_done",  32'(bus.done), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_nodone_%0d", c), 32'(bus.done | bus.w_valid | bus.busy), 0);
        end
        run_burst("post_abort", 11'd100, 11'd2, 32'hFFFF_FFFF, 1'b0);

        // Asynchronous reset in the middle of a stalled burst.
        bus.base_addr = 11'd0; bus.len = 11'd8; bus.start = 1'b1; bus.w_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst_pre_valid", 32'(bus.w_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        #2 rst_n = 1'b1;
        tick();
        check("midrst_after_done", 32'(bus.done), 0);

        run_burst("restart", 11'd20, 11'd3, 32'hDB6D_B6DB, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Sequences burst reads from one neuron's weight memory: 1-cycle read latency, read port ren/raddr[addressWidth:0]/wout.
- Turns a start command into a stream of weights using a valid/ready handshake.
- Sits between the layer controller and the neuron MAC.
- Absorbs MAC backpressure with a 2-entry skid buffer, so no weight is lost or duplicated despite memory latency.

Parameters:
addressWidth, 10, memory address width; address and length ports are addressWidth+1 bits wide.
dataWidth, 16, weight word width.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; accepted only while busy=0
base_addr  input  addressWidth+1  first weight address, latched on accepted start
len  input  addressWidth+1  number of weights to stream, latched on accepted start
abort  input  1  synchronous cancel of the current burst
busy  output  1  high from accepted start until done or abort
done  output  1  one-cycle pulse at burst completion
mem_ren  output  1  read enable to weight memory
mem_raddr  output  addressWidth+1  read address to weight memory
mem_wout  input  dataWidth  memory read data, valid the cycle after mem_ren
w_data  output  dataWidth  weight to MAC
w_valid  output  1  w_data valid
w_last  output  1  qualifies final weight of the burst (valid with w_valid)
w_ready  input  1  MAC accepts w_data when w_valid&w_ready

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; issue counter, pop counter, in-flight flag and FIFO count cleared.
- States:
  - IDLE: start=1 latches base_addr/len, sets busy; len≠0 -> RUN; len=0 -> DONE.
  - RUN: issues reads and streams weights; after the handshake of element len-1 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- start in any state other than IDLE: ignored.
- Issue rule (RUN only):
  - mem_ren=1 when issued<len, abort=0, and (fifo_count + inflight − pop_now) < 2.
  - pop_now = w_valid&w_ready this cycle.
  - mem_raddr = base+issued, modulo 2^(addressWidth+1); wrap is silent.
  - issued increments on each mem_ren.
  - While mem_ren=0, mem_raddr holds its last value.
- Return path: the inflight flag is set on a mem_ren cycle. The next cycle, mem_wout is written to the FIFO tail and the flag clears unless re-issued. Credit rule guarantees no overflow.
- Output: w_data/w_valid come from the FIFO head.
  - Head holds stable while w_valid=1 and w_ready=0.
  - w_last=1 iff head element index = len-1.
  - Simultaneous push and pop are allowed; count is unchanged.
- Latency with w_ready=1:
  - start at cycle 0 -> mem_ren, raddr=base at cycle 1.
  - w_valid with mem[base] at cycle 2.
  - Then one weight per cycle.
  - done at the cycle after the last handshake.
- Throughput: 1 weight/cycle sustained while w_ready=1. After w_ready deasserts, at most 2 words are buffered; issue stalls until space frees.
- abort=1 (any state except IDLE), effective next edge:
  - FIFO flushed; inflight data discarded; w_valid=0; mem_ren=0.
  - busy=0; done not pulsed; -> IDLE.
  - Abort in IDLE: no effect.
  - Abort and start in the same cycle: abort wins, start ignored.
- Reset mid-burst: immediate return to reset values; no done.

Test Plan:
- Basic burst: base=0, len=4, w_ready=1, mem[i]=i+16'h100 -> mem_raddr 0,1,2,3 on cycles 1-4. w_data 0x100..0x103 on cycles 2-5, w_last only with 0x103, done pulse cycle 6, busy 1->0.
- Backpressure: len=8, w_ready toggled 1,0,0,1,... random.
  - Exactly 8 handshakes with data mem[0..7] in order; no duplicates.
  - w_data stable while stalled; fifo_count never >2; mem_ren stalls when full.
- Zero length: start with len=0 -> no mem_ren, w_valid never 1, done pulse the cycle after start.
- Address wrap: addressWidth=10, base=2046, len=4 -> mem_raddr 2046, 2047, 0, 1; w_last on 4th word.
- Abort mid-burst: len=16, abort after 5th handshake while w_ready=0 and buffer full.
  - Next cycle: w_valid=0, mem_ren=0, busy=0; no done.
  - New start base=100, len=2 streams mem[100], mem[101] only.
- Reset/start collisions:
  - rst_n low mid-burst -> outputs 0 asynchronously.
  - start while busy ignored: len/base unchanged, handshake count equals original len.
